// File: rtl/core_mem_port_pkg.sv
// Shared types and constants for the per-core shared-memory port.
// Enable encodings, port FSM states and the queued request bundle.
package core_mem_port_pkg;

   localparam int REG_SIZE  = 8;
   localparam int ADDR_SIZE = 8;
   localparam int MP_DEPTH  = 4;

   localparam logic [1:0] MEM_EN_IDLE = 2'b00;
   localparam logic [1:0] MEM_EN_RD   = 2'b01;
   localparam logic [1:0] MEM_EN_WR   = 2'b10;

   typedef enum logic {
      MP_IDLE  = 1'b0,
      MP_ISSUE = 1'b1
   } mp_state_e;

   typedef struct packed {
      logic                 we;
      logic [ADDR_SIZE-1:0] addr;
      logic [REG_SIZE-1:0]  data;
   } mp_req_t;

   function automatic logic [1:0] mem_en_of(input logic we);
      return we ? MEM_EN_WR : MEM_EN_RD;
   endfunction

endpackage

// File: rtl/core_mem_port_if.sv
// Core-side request/response bundle and sh_mem-side slice bundle.
// master drives requests; slave answers them.
interface core_mem_port_if;
   import core_mem_port_pkg::*;

   logic                 req_valid;
   logic                 req_ready;
   logic                 req_we;
   logic [ADDR_SIZE-1:0] req_addr;
   logic [REG_SIZE-1:0]  req_wdata;
   logic                 rsp_valid;
   logic [REG_SIZE-1:0]  rsp_data;
   logic                 st_done;
   logic                 busy;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_data, st_done, busy
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_data, st_done, busy
   );
endinterface

interface sh_mem_if;
   import core_mem_port_pkg::*;

   logic [1:0]           mem_enable;
   logic [ADDR_SIZE-1:0] mem_addr;
   logic [REG_SIZE-1:0]  mem_wr_data;
   logic [REG_SIZE-1:0]  mem_rd_data;
   logic                 mem_ready;

   modport master (
      output mem_enable, mem_addr, mem_wr_data,
      input  mem_rd_data, mem_ready
   );

   modport slave (
      input  mem_enable, mem_addr, mem_wr_data,
      output mem_rd_data, mem_ready
   );
endinterface

// File: rtl/core_mem_port_req_fifo.sv
// Request FIFO; the head stays queued until its access completes.
// nxt/nxt_vld expose the entry that becomes head after a pop.
module core_mem_port_req_fifo
   import core_mem_port_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic    clk,
   input  logic    reset,
   input  logic    push,
   input  logic    pop,
   input  mp_req_t din,
   output mp_req_t head,
   output mp_req_t nxt,
   output logic    nxt_vld,
   output logic    full,
   output logic    empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] rd_nxt;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          push_ok, pop_ok;
   mp_req_t       mem_q [DEPTH];

   always_comb begin
      full     = (cnt_q == CW'(DEPTH));
      empty    = (cnt_q == '0);
      push_ok  = push & ~full;
      pop_ok   = pop & ~empty;
      wr_ptr_d = wr_ptr_q + PW'(push_ok);
      rd_ptr_d = rd_ptr_q + PW'(pop_ok);
      cnt_d    = cnt_q + CW'(push_ok) - CW'(pop_ok);
      rd_nxt   = rd_ptr_q + PW'(1);
      head     = mem_q[rd_ptr_q];
      // A lone entry being replaced by a same-cycle push forwards din
      nxt      = (cnt_q > CW'(1)) ? mem_q[rd_nxt] : din;
      nxt_vld  = (cnt_q > CW'(1)) | push_ok;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/core_mem_port.sv
// Per-core load/store front end: queues requests, issues one at a
// time on the sh_mem slice, holds it until ready, returns load data.
module core_mem_port
   import core_mem_port_pkg::*;
#(
   parameter int DEPTH = MP_DEPTH
) (
   input  logic     clk,
   input  logic     reset,
   core_mem_port_if.slave core,
   sh_mem_if.master       mem
);

   mp_state_e           state_q, state_d;
   mp_req_t             iss_q, iss_d;
   logic [REG_SIZE-1:0] rdata_q, rdata_d;

   mp_req_t din, head, nxt;
   logic    nxt_vld, full, empty;
   logic    push, done;

   assign din = '{we:   core.req_we,
                  addr: core.req_addr,
                  data: core.req_wdata};

   assign core.req_ready = ~full & reset;
   assign push = core.req_valid & core.req_ready;
   assign done = (state_q == MP_ISSUE) & mem.mem_ready;

   core_mem_port_req_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk    (clk),
      .reset  (reset),
      .push   (push),
      .pop    (done),
      .din    (din),
      .head   (head),
      .nxt    (nxt),
      .nxt_vld(nxt_vld),
      .full   (full),
      .empty  (empty)
   );

   always_comb begin
      state_d = state_q;
      iss_d   = iss_q;
      rdata_d = rdata_q;
      unique case (state_q)
         MP_IDLE: begin
            if (!empty) begin
               state_d = MP_ISSUE;
               iss_d   = head;
            end
         end
         MP_ISSUE: begin
            if (mem.mem_ready) begin
               if (nxt_vld)
                  iss_d = nxt;
               else
                  state_d = MP_IDLE;
            end
         end
         default: state_d = MP_IDLE;
      endcase
      if (done & ~iss_q.we)
         rdata_d = mem.mem_rd_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= MP_IDLE;
         iss_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         iss_q   <= iss_d;
         rdata_q <= rdata_d;
      end
   end

   // Drop enable while ready is high so sh_mem cannot re-grant
   assign mem.mem_enable =
      (state_q == MP_ISSUE && !mem.mem_ready) ?
      mem_en_of(iss_q.we) : MEM_EN_IDLE;
   assign mem.mem_addr    = iss_q.addr;
   assign mem.mem_wr_data = iss_q.data;

   assign core.rsp_valid = done & ~iss_q.we;
   assign core.st_done   = done & iss_q.we;
   assign core.rsp_data  =
      core.rsp_valid ? mem.mem_rd_data : rdata_q;
   assign core.busy = ~empty | (state_q == MP_ISSUE);

endmodule
